// File: rtl/cpu_mem_axi_bridge_pkg.sv
// cpu_mem_axi_bridge_pkg: FSM states and AXI encodings for the CPU data-port bridge
package cpu_mem_axi_bridge_pkg;
  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, RD_RESP, WR_REQ, WR_B} state_t;
  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/cpu_mem_axi_bridge.sv
// cpu_mem_axi_bridge: CPU valid/ready data port to single-beat AXI4 master, one transaction in flight
module cpu_mem_axi_bridge
  import cpu_mem_axi_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [DATA_WIDTH-1:0]   Write_data,
  input  logic [DATA_WIDTH/8-1:0] Write_strb,
  output logic                    Mem_Req_Ready,
  output logic [DATA_WIDTH-1:0]   Read_data,
  output logic                    Read_data_Valid,
  input  logic                    Read_data_Ready,
  output logic [ADDR_WIDTH-1:0]   cpu_mem_araddr,
  output logic                    cpu_mem_arvalid,
  input  logic                    cpu_mem_arready,
  output logic [2:0]              cpu_mem_arsize,
  output logic [1:0]              cpu_mem_arburst,
  output logic [7:0]              cpu_mem_arlen,
  input  logic [DATA_WIDTH-1:0]   cpu_mem_rdata,
  input  logic [1:0]              cpu_mem_rresp,
  input  logic                    cpu_mem_rlast,
  input  logic                    cpu_mem_rvalid,
  output logic                    cpu_mem_rready,
  output logic [ADDR_WIDTH-1:0]   cpu_mem_awaddr,
  output logic                    cpu_mem_awvalid,
  input  logic                    cpu_mem_awready,
  output logic [2:0]              cpu_mem_awsize,
  output logic [1:0]              cpu_mem_awburst,
  output logic [7:0]              cpu_mem_awlen,
  output logic [DATA_WIDTH-1:0]   cpu_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] cpu_mem_wstrb,
  output logic                    cpu_mem_wlast,
  output logic                    cpu_mem_wvalid,
  input  logic                    cpu_mem_wready,
  input  logic [1:0]              cpu_mem_bresp,
  input  logic                    cpu_mem_bvalid,
  output logic                    cpu_mem_bready,
  output logic                    bus_err
);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic aw_done, w_done, accept, aw_fire, w_fire, r_fire, b_fire;
  logic unused;
  // rlast is redundant with arlen=0; word address drops the byte offset
  assign unused = ^{cpu_mem_rlast, addr_q[1:0]};
  assign Mem_Req_Ready = state_q == IDLE;
  assign Read_data_Valid = state_q == RD_RESP;
  assign Read_data = rdata_q;
  assign cpu_mem_arvalid = state_q == RD_AR;
  assign cpu_mem_rready = state_q == RD_R;
  assign cpu_mem_awvalid = state_q == WR_REQ && !aw_done;
  assign cpu_mem_wvalid = state_q == WR_REQ && !w_done;
  assign cpu_mem_bready = state_q == WR_B;
  assign cpu_mem_araddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign cpu_mem_awaddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign cpu_mem_wdata = wdata_q;
  assign cpu_mem_wstrb = wstrb_q;
  assign cpu_mem_arsize = AXI_SIZE_WORD;
  assign cpu_mem_awsize = AXI_SIZE_WORD;
  assign cpu_mem_arburst = AXI_BURST_INCR;
  assign cpu_mem_awburst = AXI_BURST_INCR;
  assign cpu_mem_arlen = 8'd0;
  assign cpu_mem_awlen = 8'd0;
  assign cpu_mem_wlast = 1'b1;
  assign accept = Mem_Req_Ready && (MemRead || MemWrite);
  assign aw_fire = cpu_mem_awvalid && cpu_mem_awready;
  assign w_fire = cpu_mem_wvalid && cpu_mem_wready;
  assign r_fire = cpu_mem_rready && cpu_mem_rvalid;
  assign b_fire = cpu_mem_bready && cpu_mem_bvalid;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = MemWrite ? WR_REQ : MemRead ? RD_AR : IDLE;
      RD_AR:   state_d = cpu_mem_arready ? RD_R : RD_AR;
      RD_R:    state_d = cpu_mem_rvalid ? RD_RESP : RD_R;
      RD_RESP: state_d = Read_data_Ready ? IDLE : RD_RESP;
      WR_REQ:  state_d = (aw_done || aw_fire) && (w_done || w_fire) ? WR_B : WR_REQ;
      WR_B:    state_d = cpu_mem_bvalid ? IDLE : WR_B;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= Address;
        wdata_q <= Write_data;
        wstrb_q <= Write_strb;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire) w_done <= 1'b1;
      if (r_fire) rdata_q <= cpu_mem_rdata;
      if ((r_fire && cpu_mem_rresp != AXI_RESP_OKAY) || (b_fire && cpu_mem_bresp != AXI_RESP_OKAY))
        bus_err <= 1'b1;
    end
  end
endmodule

// File: doc/cpu_mem_axi_bridge.md
# cpu_mem_axi_bridge

Converts the custom CPU's valid/ready data-memory port (Address/MemRead/MemWrite/Read_data) into single-beat AXI4 master transactions. Sits directly downstream of the CPU's data port and drives the slave port of the CPU memory crossbar that splits DRAM and MMIO. One transaction outstanding at a time; no caching, no write buffering.

## Interface
- ADDR_WIDTH, 32, AXI/CPU address width
- DATA_WIDTH, 32, data width; only 32 supported
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- Address  in  32  CPU request address
- MemRead / MemWrite  in  1 each  CPU request strobes
- Write_data  in  32; Write_strb  in  4  write payload and byte enables
- Mem_Req_Ready  out  1  bridge accepts a request this cycle
- Read_data  out  32; Read_data_Valid  out  1; Read_data_Ready  in  1  read response channel
- cpu_mem_araddr  out  32; arvalid  out  1; arready  in  1; arsize  out  3; arburst  out  2; arlen  out  8
- cpu_mem_rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1
- cpu_mem_awaddr  out  32; awvalid  out  1; awready  in  1; awsize  out  3; awburst  out  2; awlen  out  8
- cpu_mem_wdata  out  32; wstrb  out  4; wlast  out  1; wvalid  out  1; wready  in  1
- cpu_mem_bresp  in  2; bvalid  in  1; bready  out  1
- bus_err  out  1  sticky: any non-OKAY rresp/bresp since reset

## Operation
- States: IDLE, RD_AR, RD_R, RD_RESP, WR_REQ, WR_B.
- IDLE: Mem_Req_Ready=1. Request accepted on (MemRead|MemWrite)&&Mem_Req_Ready; Address, Write_data, Write_strb latched.
- MemWrite wins if both strobes high (read dropped, bus_err not set).
- RD_AR: arvalid=1, araddr={addr[31:2],2'b00}; on arready -> RD_R.
- RD_R: rready=1; on rvalid, latch rdata -> RD_RESP. rlast ignored (arlen=0).
- RD_RESP: Read_data_Valid=1, Read_data stable; on Read_data_Ready -> IDLE.
- WR_REQ: awvalid and wvalid raised together; each drops the cycle after its own handshake (tracked by aw_done/w_done flags); when both done -> WR_B. AW and W may complete in either order or same cycle.
- WR_B: bready=1; on bvalid -> IDLE. No CPU-side write response.
- Constants: arsize=awsize=3'b010, arburst=awburst=2'b01 (INCR), arlen=awlen=0, wlast=1.
- rresp/bresp != 2'b00 sets bus_err; data still returned, FSM proceeds normally.

## Timing
- Reset (rst_n low at edge): state IDLE, Mem_Req_Ready=1, all AXI valids/readies 0, Read_data_Valid 0, Read_data 0, bus_err 0, done flags 0.
- Reset mid-transaction: outstanding AXI transaction abandoned; valids low the next cycle (whole system resets together).
- All outputs registered or decoded from state register only; no combinational path CPU-in -> AXI-out or AXI-in -> CPU-out.
- Mem_Req_Ready low from the cycle after acceptance until return to IDLE.
- Read, zero-wait slave: accept at edge 0, arvalid cycle 1, rready cycle 2, Read_data_Valid cycle 3; next request acceptable the cycle after Read_data_Ready.
- Write, zero-wait slave: accept edge 0, aw/wvalid cycle 1, bready cycle 2, Mem_Req_Ready high cycle 3.
- AXI valids never drop before handshake; payload held constant while valid.

## Structure
- Package cpu_mem_axi_bridge_pkg: state enum, AXI_SIZE_WORD=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00.
- Single module; no sub-module needed.

## Test plan
- Read 0x0000_1004, slave arready=1, rvalid 5 cycles later with 0xDEADBEEF -> araddr 0x1004, Read_data=0xDEADBEEF with Valid held until Read_data_Ready asserted 3 cycles late.
- Write 0x6000_0008, data 0x12345678, strb 4'b0011; wready 4 cycles before awready -> wvalid drops after W handshake, awvalid held, single bvalid closes, Mem_Req_Ready returns.
- Address 0x0000_1003 read -> araddr 0x0000_1000.
- MemRead and MemWrite both high -> only AW/W issued, no AR.
- bresp=2'b10 on a write -> bus_err=1 and stays 1 across subsequent OKAY transactions until rst_n.
- rst_n low while in RD_R -> next cycle rready=0, Mem_Req_Ready=1, Read_data_Valid=0.
